pixel_reorder_buffer: RTL and testbench
=======================================

PIXEL_REORDER_BUFFER -- requirements
Module: pixel_reorder_buffer

Interface
REQ-001 Parameter NUM_CORES, default 4: number of ray-tracing core input channels, legal range 1..8.
REQ-002 Parameter DEPTH, default 4: entries per per-core FIFO, power of two, range 2..16.
REQ-003 Parameter H_RES, default 640: pixels per line.
REQ-004 Parameter V_RES, default 480: lines per frame.
REQ-005 aclk  input  1  sole clock; all logic on the rising edge.
REQ-006 areset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle pulse that begins a frame.
REQ-008 active_cores  input  4  number of cores in use; sampled on start.
REQ-009 pix_data  input  24*NUM_CORES  per-core {r,g,b}; core k occupies bits [24k+23:24k].
REQ-010 pix_valid  input  NUM_CORES  per-core pixel valid.
REQ-011 pix_ready  output  NUM_CORES  per-core ready; a transfer occurs on valid && ready.
REQ-012 out_data  output  24  {r,g,b} to the stream packer.
REQ-013 out_valid  output  1  output pixel valid.
REQ-014 out_ready  input  1  packer ready.
REQ-015 out_user  output  1  high with the first pixel of a frame.
REQ-016 out_last  output  1  high with the last pixel of each line.
REQ-017 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 Core k is assigned pixels k, k+N, k+2N, ... of the frame, where N is the latched core count; output SHALL be in raster order.
REQ-020 Latched N SHALL be active_cores, clamped to 1 if 0 and to NUM_CORES if greater than NUM_CORES.
REQ-021 Each core SHALL have its own DEPTH-entry FIFO; pix_ready[k] SHALL be 1 only in RUN, for k < N, and while FIFO k is not full.
REQ-022 For k >= N, pix_ready[k] SHALL be 0 and pix_data[k] SHALL be ignored.
REQ-023 The read pointer rd_core SHALL start at 0 and advance by 1 on each output transfer, wrapping from N-1 to 0.
REQ-024 The output register SHALL load from FIFO rd_core when that FIFO is non-empty and the register is either empty or transferring in the same cycle; the pop and the load SHALL occur together.
REQ-025 Latency: a pixel accepted at edge E into the FIFO selected by rd_core, with the output register free, SHALL appear with out_valid high after edge E+2.
REQ-026 While out_valid && !out_ready, out_data, out_user and out_last SHALL remain stable.
REQ-027 Back-to-back operation: with data available and out_ready held high, the block SHALL sustain one output pixel per cycle.
REQ-028 x and y counters (zero-based) SHALL track the pixel held in the output register; out_user = (x==0 && y==0); out_last = (x==H_RES-1).
REQ-029 States: IDLE -> RUN on start; RUN -> IDLE when the pixel with x==H_RES-1 and y==V_RES-1 transfers.
REQ-030 frame_done SHALL pulse in the cycle after the final transfer of a frame.
REQ-031 On entry to IDLE, rd_core, x and y SHALL be cleared; FIFO contents SHALL be discarded.
REQ-032 start SHALL be ignored while in RUN; a start in the same cycle as frame completion SHALL be ignored.
REQ-033 A full FIFO whose core is not at rd_core SHALL stall only that core; the other cores SHALL be unaffected.

Reset
REQ-034 While areset is high: state=IDLE, pix_ready=0, out_valid=0, out_user=0, out_last=0, frame_done=0, busy=0, rd_core=0, x=y=0, all FIFOs empty, out_data=0.
REQ-035 Reset asserted mid-frame SHALL abort the frame at the next edge; no pixel SHALL be output until a new start.

Verification
REQ-036 N=4, H_RES=4, V_RES=2; cores return pixels in order 3,1,0,2 with values 0x0000k0 -> output order is core 0,1,2,3 and out_user is high on the first pixel only.
REQ-037 active_cores=0 -> N=1; active_cores=9 with NUM_CORES=4 -> N=4; pix_ready[3]=0 when active_cores=3.
REQ-038 Core 1 fills DEPTH entries while core 0 is silent -> pix_ready[1]=0, core 2 is still accepted, and order is restored once core 0 delivers.
REQ-039 out_ready toggled 1,0,0,1 during streaming -> out_data held while stalled and no pixel dropped or duplicated; full frame with out_ready=1 -> 8 pixels, out_last at x=3, frame_done one cycle after the last pixel.
REQ-040 areset pulsed after 5 pixels -> next cycle out_valid=0 and busy=0; after a new start, the first output pixel has out_user=1 and comes from core 0.

Source files
------------

// File: rtl/pixel_reorder_buffer.sv
// Reorders pixels arriving round-robin from several ray-tracing cores into raster
// order, with one small FIFO per core and a single registered output stage.
module pixel_reorder_buffer #(
  parameter int NUM_CORES = 4,
  parameter int DEPTH     = 4,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic [3:0]              active_cores,
  input  logic [24*NUM_CORES-1:0] pix_data,
  input  logic [NUM_CORES-1:0]    pix_valid,
  output logic [NUM_CORES-1:0]    pix_ready,
  output logic [23:0]             out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_user,
  output logic                    out_last,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int CW   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int XW   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW   = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [XW-1:0]   X_LAST   = XW'(H_RES - 1);
  localparam logic [YW-1:0]   Y_LAST   = YW'(V_RES - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [3:0]            n_q, n_d;
  logic [CW-1:0]         rd_core_q, rd_core_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [23:0]           out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_CORES-1:0]  push_q, push_d;

  logic [PW-1:0]         wr_ptr_q [NUM_CORES];
  logic [PW-1:0]         wr_ptr_d [NUM_CORES];
  logic [PW-1:0]         rd_ptr_q [NUM_CORES];
  logic [PW-1:0]         rd_ptr_d [NUM_CORES];
  logic [CNTW-1:0]       count_q  [NUM_CORES];
  logic [CNTW-1:0]       count_d  [NUM_CORES];
  logic [23:0]           mem_q    [NUM_CORES][DEPTH];

  logic [NUM_CORES-1:0]  ready, push, pop, avail;
  logic                  out_fire, last_fire, load;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    n_d          = n_q;
    rd_core_d    = rd_core_q;
    x_d          = x_q;
    y_d          = y_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;

    out_fire     = out_valid_q && out_ready;
    last_fire    = out_fire && (x_q == X_LAST) && (y_q == Y_LAST);
    frame_done_d = last_fire;

    // A freshly written entry becomes readable one cycle later, giving the two-edge latency.
    for (int k = 0; k < NUM_CORES; k++) begin
      ready[k] = !areset && (state_q == ST_RUN) && (k < int'(n_q)) && (count_q[k] != CNT_FULL);
      push[k]  = pix_valid[k] && ready[k];
      avail[k] = count_q[k] > CNTW'(push_q[k]);
    end
    push_d = push;

    load = (state_q == ST_RUN) && avail[rd_core_q] && (!out_valid_q || out_ready) && !last_fire;
    pop  = '0;
    pop[rd_core_q] = load;

    for (int k = 0; k < NUM_CORES; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k] + PW'(push[k]);
      rd_ptr_d[k] = rd_ptr_q[k] + PW'(pop[k]);
      count_d[k]  = count_q[k] + CNTW'(push[k]) - CNTW'(pop[k]);
    end

    if (load) begin
      out_data_d  = mem_q[rd_core_q][rd_ptr_q[rd_core_q]];
      out_valid_d = 1'b1;
      if (int'(rd_core_q) == int'(n_q) - 1) rd_core_d = '0;
      else                                  rd_core_d = rd_core_q + CW'(1);
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    // x/y describe the pixel sitting in the output register, so they step on its departure.
    if (out_fire) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_RUN;
        if (active_cores == 4'd0)                n_d = 4'd1;
        else if (int'(active_cores) > NUM_CORES) n_d = 4'(NUM_CORES);
        else                                     n_d = active_cores;
      end
      ST_RUN:  if (last_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Entering or sitting in IDLE flushes the pipeline and every FIFO.
    if (state_d == ST_IDLE) begin
      rd_core_d   = '0;
      x_d         = '0;
      y_d         = '0;
      out_valid_d = 1'b0;
      push_d      = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        wr_ptr_d[k] = '0;
        rd_ptr_d[k] = '0;
        count_d[k]  = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      n_q          <= 4'd1;
      rd_core_q    <= '0;
      x_q          <= '0;
      y_q          <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      push_q       <= '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      rd_core_q    <= rd_core_d;
      x_q          <= x_d;
      y_q          <= y_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      push_q       <= push_d;
      for (int k = 0; k < NUM_CORES; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        count_q[k]  <= count_d[k];
      end
    end
  end

  // NOTE: storage is not reset; the counts alone decide which entries are meaningful.
  always_ff @(posedge aclk) begin
    for (int k = 0; k < NUM_CORES; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= pix_data[24*k +: 24];
    end
  end

  assign pix_ready  = ready;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_user   = out_valid_q && (x_q == '0) && (y_q == '0);
  assign out_last   = out_valid_q && (x_q == X_LAST);
  assign frame_done = frame_done_q;
  assign busy       = (state_q == ST_RUN);

endmodule

// File: tb/tb_pixel_reorder_buffer.sv
// Directed bench for pixel_reorder_buffer on a 4x2 frame with four cores.
module tb_pixel_reorder_buffer;

  localparam int NC = 4;
  localparam int DP = 4;
  localparam int HR = 4;
  localparam int VR = 2;

  logic            clk = 1'b0;
  logic            areset;
  logic            start;
  logic [3:0]      active_cores;
  logic [24*NC-1:0] pix_data;
  logic [NC-1:0]   pix_valid;
  logic [NC-1:0]   pix_ready;
  logic [23:0]     out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_user;
  logic            out_last;
  logic            frame_done;
  logic            busy;

  always #5 clk = ~clk;

  pixel_reorder_buffer #(.NUM_CORES(NC), .DEPTH(DP), .H_RES(HR), .V_RES(VR)) dut (
    .aclk(clk), .areset(areset), .start(start), .active_cores(active_cores),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_user(out_user), .out_last(out_last), .frame_done(frame_done), .busy(busy)
  );

  typedef struct {
    logic [23:0] data;
    logic        user;
    logic        last;
    int          cyc;
  } out_rec_t;

  typedef struct {
    logic [3:0] ac;
    logic [3:0] exp_ready;
  } cfg_vec_t;

  out_rec_t q[$];
  int cyc = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output transfers and frame_done pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid && out_ready) q.push_back('{data: out_data, user: out_user, last: out_last, cyc: cyc});
    if (frame_done) begin
      fd_count = fd_count + 1;
      fd_cyc   = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    areset = 1'b1; start = 1'b0; pix_valid = '0; out_ready = 1'b0; active_cores = 4'd0;
    tick;
    tick;
    areset = 1'b0;
  endtask

  task automatic start_frame(input logic [3:0] ac);
    active_cores = ac;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic send(input int core, input logic [23:0] d);
    int n = 0;
    pix_data[24*core +: 24] = d;
    pix_valid[core] = 1'b1;
    @(negedge clk);
    while (!pix_ready[core] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("send_ready_c%0d", core), 32'(pix_ready[core]), 32'd1);
    tick;
    pix_valid[core] = 1'b0;
  endtask

  task automatic wait_outputs(input int want, input int budget, input string name);
    int n = 0;
    while (q.size() < want && n < budget) begin
      tick;
      n++;
    end
    check(name, q.size(), want);
  endtask

  cfg_vec_t vecs[6];
  int ord[8];
  int base, fdb, lastcnt;

  initial begin
    vecs[0] = '{ac: 4'd0,  exp_ready: 4'b0001};
    vecs[1] = '{ac: 4'd1,  exp_ready: 4'b0001};
    vecs[2] = '{ac: 4'd3,  exp_ready: 4'b0111};
    vecs[3] = '{ac: 4'd4,  exp_ready: 4'b1111};
    vecs[4] = '{ac: 4'd9,  exp_ready: 4'b1111};
    vecs[5] = '{ac: 4'd15, exp_ready: 4'b1111};
    ord = '{3, 1, 0, 2, 7, 5, 4, 6};

    areset = 1'b1; start = 1'b0; active_cores = 4'd4; pix_data = '0;
    pix_valid = '1; out_ready = 1'b1;

    // Reset state, with inputs deliberately active.
    @(negedge clk);
    check("rst_pix_ready",  32'(pix_ready),  32'd0);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_user",   32'(out_user),   32'd0);
    check("rst_out_last",   32'(out_last),   32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_out_data",   32'(out_data),   32'd0);
    tick;
    do_reset;

    // Core-count clamping seen through pix_ready.
    for (int i = 0; i < 6; i++) begin
      do_reset;
      start_frame(vecs[i].ac);
      @(negedge clk);
      check($sformatf("ready_ac%0d", vecs[i].ac), 32'(pix_ready), 32'(vecs[i].exp_ready));
      check($sformatf("busy_ac%0d", vecs[i].ac), 32'(busy), 32'd1);
      tick;
    end

    // start during RUN must not relatch the core count.
    do_reset;
    start_frame(4'd3);
    start_frame(4'd4);
    @(negedge clk);
    check("start_ignored_run", 32'(pix_ready), 32'h7);
    tick;

    // Single core: read pointer wraps 0 -> 0.
    do_reset;
    start_frame(4'd0);
    out_ready = 1'b1;
    base = q.size();
    send(0, 24'h0A0B0C);
    send(0, 24'h0D0E0F);
    wait_outputs(base + 2, 20, "n1_count");
    check("n1_pix0", 32'(q[base].data),     32'h0A0B0C);
    check("n1_pix1", 32'(q[base + 1].data), 32'h0D0E0F);

    // Full frame, cores out of order, out_ready held high.
    do_reset;
    start_frame(4'd4);
    out_ready = 1'b1;
    base = q.size();
    fdb  = fd_count;
    for (int i = 0; i < 8; i++) send(ord[i] % 4, 24'(ord[i] << 4));
    wait_outputs(base + 8, 60, "frame_count");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("frame_data%0d", i), 32'(q[base + i].data), 32'(i << 4));
      check($sformatf("frame_user%0d", i), 32'(q[base + i].user), 32'(i == 0));
      check($sformatf("frame_last%0d", i), 32'(q[base + i].last), 32'(i % 4 == 3));
    end
    repeat (3) tick;
    check("frame_done_once", fd_count, fdb + 1);
    check("frame_done_cycle", fd_cyc, q[base + 7].cyc + 1);
    check("frame_idle_busy", 32'(busy), 32'd0);

    // Two-edge latency, then stall pattern 1,0,0,1 and back-to-back drain.
    do_reset;
    start_frame(4'd4);
    out_ready = 1'b0;
    base = q.size();
    send(0, 24'h000000);
    @(negedge clk);
    check("lat_after_e",  32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_after_e1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_after_e2", 32'(out_valid), 32'd1);
    check("lat_user",     32'(out_user),  32'd1);
    tick;
    for (int i = 1; i < 8; i++) send(i % 4, 24'(i << 4));
    out_ready = 1'b1;
    @(negedge clk);
    tick;
    out_ready = 1'b0;
    @(negedge clk);
    check("hold1_valid", 32'(out_valid), 32'd1);
    check("hold1_data",  32'(out_data),  32'h10);
    tick;
    @(negedge clk);
    check("hold2_data",  32'(out_data),  32'h10);
    check("hold2_user",  32'(out_user),  32'd0);
    check("hold2_last",  32'(out_last),  32'd0);
    tick;
    out_ready = 1'b1;
    wait_outputs(base + 8, 40, "stall_count");
    for (int i = 0; i < 8; i++)
      check($sformatf("stall_data%0d", i), 32'(q[base + i].data), 32'(i << 4));
    check("b2b_span", q[base + 7].cyc - q[base + 1].cyc, 6);

    // Core 1 fills its FIFO while core 0 is silent.
    do_reset;
    start_frame(4'd4);
    out_ready = 1'b0;
    base = q.size();
    send(1, 24'h000010);
    send(1, 24'h000050);
    send(1, 24'h000090);
    send(1, 24'h0000D0);
    @(negedge clk);
    check("c1_full_ready", 32'(pix_ready), 32'hD);
    tick;
    send(2, 24'h000020);
    @(negedge clk);
    check("c0_silent_valid", 32'(out_valid), 32'd0);
    tick;
    send(0, 24'h000000);
    send(3, 24'h000030);
    send(0, 24'h000040);
    send(2, 24'h000060);
    send(3, 24'h000070);
    lastcnt = 0;
    for (int n = 0; n < 40 && lastcnt < 2; n++) begin
      tick;
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready && out_last) begin
        lastcnt++;
        if (lastcnt == 2) begin
          start = 1'b1;
          active_cores = 4'd4;
        end
      end
    end
    check("full_last_seen", lastcnt, 2);
    tick;
    start = 1'b0;
    @(negedge clk);
    check("start_at_done_busy", 32'(busy),       32'd0);
    check("start_at_done_fd",   32'(frame_done), 32'd1);
    tick;
    wait_outputs(base + 8, 4, "full_count");
    for (int i = 0; i < 8; i++)
      check($sformatf("full_data%0d", i), 32'(q[base + i].data), 32'(i << 4));
    start_frame(4'd4);
    base = q.size();
    send(0, 24'hAA0000);
    repeat (6) tick;
    check("discard_count", q.size(), base + 1);
    check("discard_data",  32'(q[base].data), 32'hAA0000);

    // Reset mid-frame after five pixels.
    do_reset;
    start_frame(4'd4);
    out_ready = 1'b1;
    base = q.size();
    for (int i = 0; i < 5; i++) send(i % 4, 24'(i << 4));
    wait_outputs(base + 5, 20, "abort_count");
    areset = 1'b1;
    tick;
    areset = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy",  32'(busy),      32'd0);
    tick;
    base = q.size();
    pix_data  = {4{24'h555555}};
    pix_valid = '1;
    repeat (3) tick;
    @(negedge clk);
    check("abort_idle_ready", 32'(pix_ready), 32'd0);
    tick;
    pix_valid = '0;
    check("abort_no_output", q.size(), base);
    start_frame(4'd4);
    base = q.size();
    send(1, 24'h111111);
    send(0, 24'hABCDEF);
    wait_outputs(base + 2, 20, "restart_count");
    check("restart_first_data", 32'(q[base].data),     32'hABCDEF);
    check("restart_first_user", 32'(q[base].user),     32'd1);
    check("restart_second",     32'(q[base + 1].data), 32'h111111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
